axil_reg_slave: RTL and testbench
=================================

Name: axil_reg_slave

Overview:
AXI4-Lite responder endpoint that terminates one slave port of the AXI-Lite interconnect. It implements REG_NUM 32-bit read/write registers with byte strobes and exports them to the core as a flat vector. Write and read channels are independent: write uses a two-state FSM (accept / respond), read uses a two-state FSM (accept / respond). Out-of-window accesses return SLVERR and have no side effects.

Parameters:
- REG_NUM, 8, number of 32-bit registers (1..64).
- BASE, 32'h0000_0000, byte address of register 0; must be 4-byte aligned; the full bus address is decoded against it.
- RESET_VAL, {32*REG_NUM{1'b0}}, per-register reset values, register i in bits [32*i+:32].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- s_axi_awaddr  in  `ADRES_BIT  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awprot  in  3  ignored.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  `VERI_BIT  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  `ADRES_BIT  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arprot  in  3  ignored.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  `VERI_BIT  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- reg_o  out  32*REG_NUM  current register contents.
- reg_wr_o  out  REG_NUM  one-cycle pulse per register on a successful write.

Behaviour:
- Reset (rst_i high at posedge): registers load RESET_VAL; bvalid, rvalid, reg_wr_o and the aw_hold/w_hold flags go to 0; bresp, rresp and rdata go to 0. While rst_i is high, awready, wready and arready are forced to 0. Reset mid-transaction drops any pending response; no B or R beat is emitted for it.
- Decode: in-window when BASE <= addr < BASE + 4*REG_NUM. Index = (addr - BASE) >> 2. addr[1:0] is ignored.
- Write FSM W_IDLE:
  - awready = !aw_hold; wready = !w_hold.
  - AW and W handshake independently. An accepted AW latches the address and sets aw_hold; an accepted W latches data and strobe and sets w_hold.
  - When both are available (held, or arriving this cycle), the write commits at that edge:
    - In-window: bytes with wstrb[k]=1 are updated; reg_wr_o[idx] pulses the next cycle; bresp = OKAY.
    - Out-of-window: no update; bresp = SLVERR (2'b10).
  - Commit clears both hold flags, sets bvalid and moves to W_RESP.
- Write FSM W_RESP: awready = wready = 0. bvalid and bresp are held stable until bready. On bvalid & bready, go to W_IDLE; awready/wready can be 1 in that same cycle. No combinational path from bready to awready.
- Write latency: AW and W in the same cycle (edge N) -> register updated and bvalid high from N+1. Minimum 2 cycles per write with bready tied high.
- Read FSM R_IDLE: arready = 1. On arvalid & arready, register rdata from the current register value (0 if out-of-window) and set rresp to OKAY or SLVERR. Set rvalid and go to R_DATA.
- Read FSM R_DATA: arready = 0. rdata, rresp and rvalid are held stable until rready, then go to R_IDLE.
- Simultaneous read and write commit to the same register at the same edge: the read returns the pre-write value.
- reg_o is a direct register output: a new value is visible one cycle after commit. All outputs are registered except the readies, which decode FSM state and hold flags only.
- wstrb = 4'b0000 in-window: no byte changes, reg_wr_o still pulses, bresp = OKAY.

Decomposition:
- Shared include sabitler.vh: `ADRES_BIT, `VERI_BIT, `HIGH/`LOW. Add `AXI_RESP_OKAY (2'b00) and `AXI_RESP_SLVERR (2'b10) there for reuse by other responders.
- No sub-module. The address-decode and strobe-merge logic is small enough to live in this file as functions.

Test Plan:
- Reset with RESET_VAL reg1 = 32'hDEAD_BEEF -> read 0x04 returns rdata = 32'hDEAD_BEEF, rresp = 00, rvalid one cycle after the AR handshake.
- Same-cycle AW 0x08 and W 32'h1234_5678 with strb 4'hF -> reg_o[95:64] = 32'h1234_5678 and bvalid/bresp = 00 at the next edge, reg_wr_o = 8'b0000_0100 for one cycle.
- W leads AW by 3 cycles, strb 4'b0010, data 32'hAABB_CCDD onto 0 -> wready low after the W handshake, register = 32'h0000_CC00 after AW arrives.
- AW 0x20 with REG_NUM = 8 (out-of-window) -> bresp = 10, no reg_o change, no reg_wr_o pulse. AR 0x20 -> rdata = 0, rresp = 10.
- bready held low for 5 cycles -> bvalid/bresp stable, awready = wready = 0 throughout. A second AW is accepted only after the B handshake.
- rst_i asserted while rvalid pending and rready = 0 -> rvalid = 0 next edge, arready = 0 during reset and 1 after.

Source files
------------

// File: rtl/axil_reg_slave_pkg.sv
// Shared bus-width and response-code macros plus the state types used by the
// AXI4-Lite register responder. The macro block is guarded so other responders
// that pull in the same definitions do not redefine them.
`ifndef SABITLER_VH
`define SABITLER_VH
`define ADRES_BIT        32
`define VERI_BIT         32
`define HIGH             1'b1
`define LOW              1'b0
`define AXI_RESP_OKAY    2'b00
`define AXI_RESP_SLVERR  2'b10
`endif

package axil_reg_slave_pkg;

   localparam int unsigned REG_W  = 32;
   localparam int unsigned STRB_W = REG_W / 8;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } w_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_t;

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder with REG_NUM 32-bit byte-strobed registers exported as a
// flat vector. Write and read channels run independent two-state FSMs; accesses
// outside [BASE, BASE + 4*REG_NUM) complete with SLVERR and change nothing.
module axil_reg_slave
   import axil_reg_slave_pkg::*;
#(
   parameter int unsigned            REG_NUM   = 8,
   parameter logic [`ADRES_BIT-1:0]  BASE      = 32'h0000_0000,
   parameter logic [32*REG_NUM-1:0]  RESET_VAL = {32*REG_NUM{1'b0}}
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [`ADRES_BIT-1:0]  s_axi_awaddr,
   input  logic                   s_axi_awvalid,
   input  logic [2:0]             s_axi_awprot,
   output logic                   s_axi_awready,
   input  logic [`VERI_BIT-1:0]   s_axi_wdata,
   input  logic [3:0]             s_axi_wstrb,
   input  logic                   s_axi_wvalid,
   output logic                   s_axi_wready,
   output logic [1:0]             s_axi_bresp,
   output logic                   s_axi_bvalid,
   input  logic                   s_axi_bready,
   input  logic [`ADRES_BIT-1:0]  s_axi_araddr,
   input  logic                   s_axi_arvalid,
   input  logic [2:0]             s_axi_arprot,
   output logic                   s_axi_arready,
   output logic [`VERI_BIT-1:0]   s_axi_rdata,
   output logic [1:0]             s_axi_rresp,
   output logic                   s_axi_rvalid,
   input  logic                   s_axi_rready,
   output logic [32*REG_NUM-1:0]  reg_o,
   output logic [REG_NUM-1:0]     reg_wr_o
);

   localparam int unsigned ADDR_W = `ADRES_BIT;
   localparam int unsigned IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
   localparam logic [ADDR_W:0] WIN_SPAN = (ADDR_W + 1)'(4 * REG_NUM);

   // Borrow-based window test: a single subtraction covers both bounds and
   // stays correct when BASE + window size wraps past the top of the map.
   function automatic logic in_window(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W:0] diff;
      diff = {1'b0, addr} - {1'b0, BASE};
      return !diff[ADDR_W] && (diff < WIN_SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] offset;
      offset = addr - BASE;
      return IDX_W'(offset >> 2);
   endfunction

   function automatic logic [REG_W-1:0] strb_merge(input logic [REG_W-1:0]  old_val,
                                                   input logic [REG_W-1:0]  new_val,
                                                   input logic [STRB_W-1:0] strb);
      logic [REG_W-1:0] merged;
      merged = old_val;
      for (int k = 0; k < STRB_W; k++) begin
         if (strb[k]) merged[8*k +: 8] = new_val[8*k +: 8];
      end
      return merged;
   endfunction

   logic [REG_W-1:0]   regs [REG_NUM];
   w_state_t           w_state;
   r_state_t           r_state;
   logic               aw_hold, w_hold;
   logic [ADDR_W-1:0]  aw_addr;
   logic [REG_W-1:0]   w_data;
   logic [STRB_W-1:0]  w_strb;

   logic               aw_fire, w_fire, wr_commit, wr_ok, rd_ok;
   logic [ADDR_W-1:0]  wr_addr;
   logic [REG_W-1:0]   wr_data;
   logic [STRB_W-1:0]  wr_strb;
   logic [IDX_W-1:0]   wr_idx, rd_idx;

   // Protection bits carry no meaning for this register block.
   logic unused_prot;
   assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

   // Readies depend only on state, hold flags and reset, never on bready/rready.
   assign s_axi_awready = !rst_i && (w_state == W_IDLE) && !aw_hold;
   assign s_axi_wready  = !rst_i && (w_state == W_IDLE) && !w_hold;
   assign s_axi_arready = !rst_i && (r_state == R_IDLE);

   // Pick held or arriving AW/W beats and decide whether a write commits now.
   always_comb begin
      aw_fire   = s_axi_awvalid && s_axi_awready;
      w_fire    = s_axi_wvalid  && s_axi_wready;
      wr_addr   = aw_hold ? aw_addr : s_axi_awaddr;
      wr_data   = w_hold  ? w_data  : s_axi_wdata;
      wr_strb   = w_hold  ? w_strb  : s_axi_wstrb;
      wr_commit = (w_state == W_IDLE) && (aw_hold || aw_fire) && (w_hold || w_fire);
      wr_ok     = in_window(wr_addr);
      wr_idx    = word_idx(wr_addr);
      rd_ok     = in_window(s_axi_araddr);
      rd_idx    = word_idx(s_axi_araddr);
   end

   // Write FSM: collect AW and W in any order, commit, then hold B until taken.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state      <= W_IDLE;
         aw_hold      <= 1'b0;
         w_hold       <= 1'b0;
         aw_addr      <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= `AXI_RESP_OKAY;
         reg_wr_o     <= '0;
         // NOTE: the register file needs a reset here because the core sees
         // reg_o directly; a plain RAM without reset would expose garbage.
         for (int i = 0; i < REG_NUM; i++) regs[i] <= RESET_VAL[32*i +: 32];
      end else begin
         reg_wr_o <= '0;
         case (w_state)
            W_IDLE: begin
               if (wr_commit) begin
                  if (wr_ok) begin
                     regs[wr_idx]     <= strb_merge(regs[wr_idx], wr_data, wr_strb);
                     reg_wr_o[wr_idx] <= 1'b1;
                     s_axi_bresp      <= `AXI_RESP_OKAY;
                  end else begin
                     s_axi_bresp      <= `AXI_RESP_SLVERR;
                  end
                  aw_hold      <= 1'b0;
                  w_hold       <= 1'b0;
                  s_axi_bvalid <= 1'b1;
                  w_state      <= W_RESP;
               end else begin
                  if (aw_fire) begin
                     aw_addr <= s_axi_awaddr;
                     aw_hold <= 1'b1;
                  end
                  if (w_fire) begin
                     w_data <= s_axi_wdata;
                     w_strb <= s_axi_wstrb;
                     w_hold <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid <= 1'b0;
                  w_state      <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read FSM: sample the register on AR, hold R until the master takes it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= R_IDLE;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= `AXI_RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (s_axi_arvalid) begin
                  s_axi_rdata  <= rd_ok ? regs[rd_idx] : '0;
                  s_axi_rresp  <= rd_ok ? `AXI_RESP_OKAY : `AXI_RESP_SLVERR;
                  s_axi_rvalid <= 1'b1;
                  r_state      <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  s_axi_rvalid <= 1'b0;
                  r_state      <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Flatten the register file onto the core-facing vector.
   always_comb begin
      reg_o = '0;
      for (int i = 0; i < REG_NUM; i++) reg_o[32*i +: 32] = regs[i];
   end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: directed scenarios plus randomized traffic checked
// against an array model of the register map.
module tb_axil_reg_slave;

   localparam int NREG = 8;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam logic [32*NREG-1:0] RV = {32'h0, 32'h0, 32'h0BAD_F00D, 32'h0,
                                        32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};

   logic clk = 1'b0;
   logic rst_i;
   logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
   logic [2:0]  s_axi_awprot, s_axi_arprot;
   logic [3:0]  s_axi_wstrb;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic s_axi_rvalid, s_axi_rready;
   logic [32*NREG-1:0] reg_o;
   logic [NREG-1:0]    reg_wr_o;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] model [NREG];

   axil_reg_slave #(.REG_NUM(NREG), .BASE(BASE), .RESET_VAL(RV)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awprot(s_axi_awprot),
      .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arprot(s_axi_arprot), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready), .reg_o(reg_o), .reg_wr_o(reg_wr_o)
   );

   always #5 clk = ~clk;

   function automatic bit m_in_win(input logic [31:0] addr);
      longint off;
      off = longint'(addr) - longint'(BASE);
      return (off >= 0) && (off < 4 * NREG);
   endfunction

   function automatic int m_idx(input logic [31:0] addr);
      return int'((addr - BASE) / 4);
   endfunction

   function automatic logic [32*NREG-1:0] model_flat();
      logic [32*NREG-1:0] f;
      for (int i = 0; i < NREG; i++) f[32*i +: 32] = model[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) model[i] = RV[32*i +: 32];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One write with W leading AW by 'lead' cycles (negative: AW leads), then
   // bready held low for 'stall' cycles before the B handshake.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, input int stall);
      bit aw_done = 0, w_done = 0, aw_f, w_f, timed_out = 0;
      int aw_start, w_start, c = 0;
      logic [1:0] exp_resp;
      logic [NREG-1:0] exp_wr = '0;
      if (m_in_win(addr)) begin
         for (int k = 0; k < 4; k++)
            if (strb[k]) model[m_idx(addr)][8*k +: 8] = data[8*k +: 8];
         exp_wr[m_idx(addr)] = 1'b1;
         exp_resp = 2'b00;
      end else begin
         exp_resp = 2'b10;
      end
      aw_start = (lead > 0) ? lead : 0;
      w_start  = (lead < 0) ? -lead : 0;
      s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_bready = 0;
      while (!(aw_done && w_done) && !timed_out) begin
         s_axi_awvalid = !aw_done && (c >= aw_start);
         s_axi_wvalid  = !w_done  && (c >= w_start);
         if (w_done && !aw_done) begin
            vectors++;
            if (s_axi_wready !== 1'b0) begin
               miscompares++;
               $display("FAIL wready_after_w: got %b want 0 addr=%h", s_axi_wready, addr);
            end
         end
         if (aw_done && !w_done) begin
            vectors++;
            if (s_axi_awready !== 1'b0) begin
               miscompares++;
               $display("FAIL awready_after_aw: got %b want 0 addr=%h", s_axi_awready, addr);
            end
         end
         aw_f = s_axi_awvalid && s_axi_awready;
         w_f  = s_axi_wvalid  && s_axi_wready;
         tick();
         aw_done |= aw_f; w_done |= w_f; c++;
         if (c > 40) timed_out = 1;
      end
      s_axi_awvalid = 0; s_axi_wvalid = 0;
      vectors++;
      if (timed_out) begin
         miscompares++;
         $display("FAIL write_handshake_timeout: addr=%h aw_done=%b w_done=%b", addr, aw_done, w_done);
      end
      vectors++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_resp || reg_wr_o !== exp_wr || reg_o !== model_flat()) begin
         miscompares++;
         $display("FAIL write_commit addr=%h: bvalid=%b bresp=%b wr=%b reg_o=%h want bvalid=1 bresp=%b wr=%b reg_o=%h",
                  addr, s_axi_bvalid, s_axi_bresp, reg_wr_o, reg_o, exp_resp, exp_wr, model_flat());
      end
      for (int s = 0; s < stall; s++) begin
         tick();
         vectors++;
         if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_resp || s_axi_awready !== 1'b0 ||
             s_axi_wready !== 1'b0 || reg_wr_o !== '0) begin
            miscompares++;
            $display("FAIL b_stall cyc%0d: bvalid=%b bresp=%b awready=%b wready=%b wr=%b want 1 %b 0 0 0",
                     s, s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready, reg_wr_o, exp_resp);
         end
      end
      s_axi_bready = 1;
      tick();
      s_axi_bready = 0;
      vectors++;
      if (s_axi_bvalid !== 1'b0 || reg_wr_o !== '0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin
         miscompares++;
         $display("FAIL b_done: bvalid=%b wr=%b awready=%b wready=%b want 0 0 1 1",
                  s_axi_bvalid, reg_wr_o, s_axi_awready, s_axi_wready);
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input int stall);
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      bit fired = 0;
      int c = 0;
      exp_data = m_in_win(addr) ? model[m_idx(addr)] : 32'h0;
      exp_resp = m_in_win(addr) ? 2'b00 : 2'b10;
      s_axi_araddr = addr; s_axi_arvalid = 1; s_axi_rready = 0;
      while (!fired && c < 20) begin
         fired = s_axi_arready;
         tick();
         c++;
      end
      s_axi_arvalid = 0;
      vectors++;
      if (!fired || s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp_data || s_axi_rresp !== exp_resp) begin
         miscompares++;
         $display("FAIL read addr=%h: fired=%b rvalid=%b rdata=%h rresp=%b want 1 1 %h %b",
                  addr, fired, s_axi_rvalid, s_axi_rdata, s_axi_rresp, exp_data, exp_resp);
      end
      for (int s = 0; s < stall; s++) begin
         tick();
         vectors++;
         if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp_data || s_axi_rresp !== exp_resp || s_axi_arready !== 1'b0) begin
            miscompares++;
            $display("FAIL r_stall cyc%0d: rvalid=%b rdata=%h rresp=%b arready=%b want 1 %h %b 0",
                     s, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_arready, exp_data, exp_resp);
         end
      end
      s_axi_rready = 1;
      tick();
      s_axi_rready = 0;
      vectors++;
      if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
         miscompares++;
         $display("FAIL r_done: rvalid=%b arready=%b want 0 1", s_axi_rvalid, s_axi_arready);
      end
   endtask

   task automatic test_reset();
      rst_i = 1;
      s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0; s_axi_bready = 0; s_axi_rready = 0;
      s_axi_awaddr = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_araddr = 0;
      s_axi_awprot = 0; s_axi_arprot = 0;
      model_reset();
      tick(); tick();
      vectors++;
      if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_arready !== 1'b0) begin
         miscompares++;
         $display("FAIL readies_in_reset: aw=%b w=%b ar=%b want 000", s_axi_awready, s_axi_wready, s_axi_arready);
      end
      rst_i = 0;
      #1;
      vectors++;
      if (s_axi_bvalid !== 0 || s_axi_rvalid !== 0 || reg_wr_o !== '0 || s_axi_bresp !== 0 ||
          s_axi_rresp !== 0 || s_axi_rdata !== 0 || reg_o !== RV ||
          s_axi_awready !== 1 || s_axi_wready !== 1 || s_axi_arready !== 1) begin
         miscompares++;
         $display("FAIL reset_state: bv=%b rv=%b wr=%b rdata=%h reg_o=%h rdy=%b%b%b want reg_o=%h rdy=111",
                  s_axi_bvalid, s_axi_rvalid, reg_wr_o, s_axi_rdata, reg_o,
                  s_axi_awready, s_axi_wready, s_axi_arready, RV);
      end
      tick();
      do_read(32'h04, 0);
   endtask

   task automatic test_same_cycle_write();
      do_write(32'h08, 32'h1234_5678, 4'hF, 0, 0);
      vectors++;
      if (reg_o[95:64] !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL same_cycle_reg2: got %h want 12345678", reg_o[95:64]);
      end
   endtask

   task automatic test_w_leads();
      do_write(32'h00, 32'hAABB_CCDD, 4'b0010, 3, 0);
      vectors++;
      if (reg_o[31:0] !== 32'h0000_CC00) begin
         miscompares++;
         $display("FAIL w_leads_reg0: got %h want 0000cc00", reg_o[31:0]);
      end
      do_write(32'h1D, 32'h0102_0304, 4'b1001, -2, 1);
   endtask

   task automatic test_out_of_window();
      do_write(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0);
      do_read(32'h20, 0);
      do_write(32'hFFFF_FFFC, 32'h5555_AAAA, 4'hF, 1, 0);
      do_read(32'hFFFF_FFFC, 1);
   endtask

   task automatic test_zero_strb();
      do_write(32'h14, 32'h7777_7777, 4'b0000, 0, 0);
      do_read(32'h14, 0);
   endtask

   task automatic test_bready_stall();
      do_write(32'h18, 32'hCAFE_0001, 4'hF, 0, 5);
      do_write(32'h1C, 32'hCAFE_0002, 4'hF, 0, 0);
      do_read(32'h18, 0);
      do_read(32'h1C, 2);
   endtask

   task automatic test_read_write_same_edge();
      logic [31:0] old_val, new_val;
      old_val = model[3];
      new_val = $urandom;
      s_axi_awaddr = 32'h0C; s_axi_wdata = new_val; s_axi_wstrb = 4'hF; s_axi_araddr = 32'h0C;
      s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
      tick();
      s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
      model[3] = new_val;
      vectors++;
      if (s_axi_rvalid !== 1 || s_axi_rdata !== old_val || s_axi_bvalid !== 1 || reg_o[127:96] !== new_val) begin
         miscompares++;
         $display("FAIL rw_same_edge: rvalid=%b rdata=%h bvalid=%b reg3=%h want 1 %h 1 %h",
                  s_axi_rvalid, s_axi_rdata, s_axi_bvalid, reg_o[127:96], old_val, new_val);
      end
      s_axi_bready = 1; s_axi_rready = 1;
      tick();
      s_axi_bready = 0; s_axi_rready = 0;
      do_read(32'h0C, 0);
   endtask

   task automatic test_reset_mid_read();
      s_axi_araddr = 32'h14; s_axi_arvalid = 1; s_axi_rready = 0;
      tick();
      s_axi_arvalid = 0;
      rst_i = 1;
      model_reset();
      tick();
      vectors++;
      if (s_axi_rvalid !== 0 || s_axi_arready !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_read: rvalid=%b arready=%b want 0 0", s_axi_rvalid, s_axi_arready);
      end
      rst_i = 0;
      #1;
      vectors++;
      if (s_axi_arready !== 1 || reg_o !== RV) begin
         miscompares++;
         $display("FAIL after_reset: arready=%b reg_o=%h want 1 %h", s_axi_arready, reg_o, RV);
      end
      tick();
      do_read(32'h04, 0);
   endtask

   task automatic test_random();
      logic [31:0] addr;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 4) != 0) addr = ({29'h0, 3'($urandom_range(0, NREG - 1))} << 2) | 32'($urandom_range(0, 3));
         else addr = 32'h20 + ($urandom_range(0, 1000) << 2);
         if ($urandom_range(0, 2) == 0) do_read(addr, int'($urandom_range(0, 2)));
         else do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
      end
      for (int i = 0; i < NREG; i++) do_read(32'(4 * i), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_same_cycle_write();
      test_w_leads();
      test_out_of_window();
      test_zero_strb();
      test_bready_stall();
      test_read_write_same_edge();
      test_reset_mid_read();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
